// File: rtl/cdb_result_buffer.sv
// Per-unit result FIFO feeding the CDB arbiter: buffers {tag, value} pairs and requests the bus while non-empty.
// Optional zero-latency bypass from the execution unit to the CDB is enabled by defining CDB_RESULT_BYPASS_EN.
module cdb_result_buffer #(
    parameter int DEPTH     = 4,
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    input  logic [XLEN-1:0]              in_value,
    output logic                         in_ready,
    input  logic                         flush,
    output logic                         request,
    input  logic                         grant,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    output logic [XLEN-1:0]              cdb_value,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [TAG_WIDTH-1:0] tag_mem   [DEPTH];
    logic [XLEN-1:0]      value_mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count_q;
    logic                 bypass;
    logic                 push;
    logic                 pop;
    logic                 empty;

    assign empty = (count_q == '0);

`ifdef CDB_RESULT_BYPASS_EN
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // in_ready depends on registered occupancy only, so a full buffer refuses a push even while popping
    assign in_ready  = (count_q != FULL_COUNT);
    assign request   = !empty || bypass;
    assign cdb_tag   = bypass ? in_tag   : tag_mem[head];
    assign cdb_value = bypass ? in_value : value_mem[head];
    assign count     = count_q;

    // A bypassed result that is granted in the same cycle is consumed and never stored
    assign push = in_valid && in_ready && !(bypass && grant);
    assign pop  = grant && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i]   <= '0;
                value_mem[i] <= '0;
            end
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tag_mem[tail]   <= in_tag;
                value_mem[tail] <= in_value;
                tail            <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
